// File: rtl/hpc1_rnd_pkg.sv
// hpc1_rnd_pkg: shared constants, FSM states and LFSR helpers for hpc1_rnd_source
package hpc1_rnd_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] ZERO_SUB = 32'h0000_0001;
  typedef enum logic [1:0] {UNSEEDED, LOAD, WARM, RUN} state_t;
  function automatic int n_lfsr(input int nrnd);
    return (nrnd + LFSR_W - 1) / LFSR_W;
  endfunction
  // 32 right-shift Galois steps, so every advance yields an entirely new word
  function automatic logic [LFSR_W-1:0] lfsr_adv32(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < LFSR_W; i++) r = {1'b0, r[LFSR_W-1:1]} ^ (r[0] ? LFSR_MASK : '0);
    return r;
  endfunction
endpackage

// File: rtl/hpc1_rnd_source_lfsr32.sv
// hpc1_lfsr32: one 32-bit Galois LFSR with zero-substituted load and 32-step advance
module hpc1_lfsr32
  import hpc1_rnd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] q_o
);
  logic [LFSR_W-1:0] q_q, q_d;
  always_comb q_d = load_i ? (seed_i == '0 ? ZERO_SUB : seed_i) : adv_i ? lfsr_adv32(q_q) : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= ZERO_SUB;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/hpc1_rnd_source.sv
// hpc1_rnd_source: seeded K x 32-bit LFSR randomness source feeding HPC1 gadgets.
// Optional health test (sticky rnd_fail) with macro RND_HEALTH_EN.
module hpc1_rnd_source
  import hpc1_rnd_pkg::*;
#(
  parameter int NRND   = 6,
  parameter int WARMUP = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     seed_in,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic            rnd_en,
  output logic [NRND-1:0] rnd,
`ifdef RND_HEALTH_EN
  output logic            rnd_fail,
`endif
  output logic            rnd_valid
);
  localparam int K  = n_lfsr(NRND);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  localparam int CW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, acc, acc_first, acc_last, consume, adv, fail, unused_hi;
  logic [K-1:0] ld;
  logic [K*LFSR_W-1:0] cat;
  assign acc = seed_valid && seed_ready;
  // a word accepted in UNSEEDED or RUN always restarts the load at LFSR0
  assign acc_first = acc && (state_q == UNSEEDED || state_q == RUN);
  assign acc_last = (acc_first && K == 1) || (acc && state_q == LOAD && idx_q == IW'(K - 1));
  assign consume = state_q == RUN && rnd_en && !acc && !fail;
  assign adv = state_q == WARM || consume;
  for (genvar i = 0; i < K; i++) begin : g_l
    assign ld[i] = acc_first ? (i == 0) : (acc && state_q == LOAD && idx_q == IW'(i));
    hpc1_lfsr32 u_l (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(ld[i]),
      .adv_i (adv),
      .seed_i(seed_in),
      .q_o   (cat[i*LFSR_W +: LFSR_W])
    );
  end
  assign unused_hi = ^cat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= UNSEEDED;
    else state_q <= state_d;
  always_comb state_d = acc_last ? (WARMUP == 0 ? RUN : WARM) : acc_first ? LOAD :
                        (state_q == WARM && cnt_q == CW'(WARMUP - 1)) ? RUN : state_q;
  always_comb seed_ready = state_q != WARM;
  always_comb begin
    cnt_d = state_q == WARM ? cnt_q + CW'(1) : '0;
    idx_d = acc_first ? IW'(1) : (acc && state_q == LOAD) ? idx_q + IW'(1) : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= state_d == RUN;
    end
  assign rnd_valid = valid_q && !fail;
  assign rnd = rnd_valid ? cat[NRND-1:0] : '0;
`ifdef RND_HEALTH_EN
  logic fail_q, fail_d, dup;
  logic [K-1:0] zero;
  for (genvar i = 0; i < K; i++) begin : g_z
    assign zero[i] = cat[i*LFSR_W +: LFSR_W] == '0;
  end
  // repeats are only meaningful once the word is wide enough to make them rare
  if (NRND >= 8) begin : g_dup
    logic [NRND-1:0] prev_q;
    logic pv_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        prev_q <= '0;
        pv_q   <= 1'b0;
      end else if (acc_first) pv_q <= 1'b0;
      else if (consume) begin
        prev_q <= rnd;
        pv_q   <= 1'b1;
      end
    assign dup = consume && pv_q && rnd == prev_q;
  end else begin : g_nodup
    assign dup = 1'b0;
  end
  always_comb fail_d = acc_first ? 1'b0 : fail_q || (|zero) || dup;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fail_q <= 1'b0;
    else fail_q <= fail_d;
  assign fail = fail_q;
  assign rnd_fail = fail_q;
`else
  assign fail = 1'b0;
`endif
endmodule

// File: tb/tb_hpc1_rnd_source.sv
// tb_hpc1_rnd_source: randomized self-checking bench against a word-level LFSR model
module tb_hpc1_rnd_source;
  logic clk = 1'b0, rst_n;
  logic [31:0] sa, sb, s;
  logic va, ena, vb, enb;
  logic rdy_a, vld_a, rdy_c, vld_c, rdy_b, vld_b;
  logic [5:0] rnd_a, rnd_c;
  logic [39:0] rnd_b;
  logic [31:0] ma, mc, mb0, mb1;
  int nvec = 0, nerr = 0;
`ifdef RND_HEALTH_EN
  logic fail_a, fail_b, fail_c;
`endif

  always #5 clk = ~clk;

  hpc1_rnd_source #(.NRND(6), .WARMUP(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_in(sa), .seed_valid(va), .seed_ready(rdy_a),
    .rnd_en(ena), .rnd(rnd_a),
`ifdef RND_HEALTH_EN
    .rnd_fail(fail_a),
`endif
    .rnd_valid(vld_a));
  hpc1_rnd_source #(.NRND(6), .WARMUP(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .seed_in(sa), .seed_valid(va), .seed_ready(rdy_c),
    .rnd_en(ena), .rnd(rnd_c),
`ifdef RND_HEALTH_EN
    .rnd_fail(fail_c),
`endif
    .rnd_valid(vld_c));
  hpc1_rnd_source #(.NRND(40), .WARMUP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_in(sb), .seed_valid(vb), .seed_ready(rdy_b),
    .rnd_en(enb), .rnd(rnd_b),
`ifdef RND_HEALTH_EN
    .rnd_fail(fail_b),
`endif
    .rnd_valid(vld_b));

  // one LFSR advance = 32 single Galois steps with taps x^32+x^22+x^2+x+1
  function automatic logic [31:0] adv(input logic [31:0] v);
    logic [31:0] r = v;
    for (int i = 0; i < 32; i++) r = r[0] ? (r >> 1) ^ 32'h8020_0003 : r >> 1;
    return r;
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] v);
    return v == 0 ? 32'h1 : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic seed_a(input logic [31:0] v, input logic en);
    sa = v; va = 1'b1; ena = en;
    @(negedge clk);
    va = 1'b0; ena = 1'b0;
    ma = ld(v);
    for (int n = 1; n < 17; n++) begin
      check("warm_vld_a", vld_a, 0);
      check("warm_rnd_a", rnd_a, 0);
      check("warm_rdy_a", rdy_a, 0);
      ma = adv(ma);
      ena = 1'($urandom);
      va = 1'($urandom);
      sa = $urandom;
      @(negedge clk);
    end
    ena = 1'b0; va = 1'b0;
    check("vld_rise_a", vld_a, 1);
    check("rnd_a", rnd_a, ma[5:0]);
    check("run_rdy_a", rdy_a, 1);
  endtask

  task automatic consume_a(input logic e);
    ena = e;
    @(negedge clk);
    ena = 1'b0;
    if (e) ma = adv(ma);
    check("run_rnd_a", rnd_a, ma[5:0]);
    check("run_vld_a", vld_a, 1);
  endtask

  task automatic consume_b(input logic e);
    enb = e;
    @(negedge clk);
    enb = 1'b0;
    if (e) begin mb0 = adv(mb0); mb1 = adv(mb1); end
    check("run_rnd_b", rnd_b, {mb1[7:0], mb0});
    check("run_vld_b", vld_b, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    sa = 0; sb = 0; va = 0; vb = 0; ena = 0; enb = 0;
    do_reset();
    check("rst_vld_a", vld_a, 0);
    check("rst_rnd_a", rnd_a, 0);
    check("rst_rdy_a", rdy_a, 1);
    check("rst_vld_b", vld_b, 0);
    check("rst_rdy_b", rdy_b, 1);
    seed_a(32'h1234_5678, 1'b0);
    consume_a(1); consume_a(0); consume_a(0); consume_a(1);
    for (int j = 0; j < 20; j++) consume_a(1'($urandom));
    // reseed collides with rnd_en: seed wins, output drops, warm-up restarts
    seed_a($urandom, 1'b1);
    for (int j = 0; j < 8; j++) consume_a(1'($urandom));
    rst_n = 1'b0;
    #1;
    check("arst_run_vld_a", vld_a, 0);
    check("arst_run_rnd_a", rnd_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seed_a(32'h0, 1'b0);
    for (int j = 0; j < 10; j++) consume_a(1'($urandom));
    do_reset();
    sa = $urandom; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_warm_rdy_a", rdy_a, 0);
    rst_n = 1'b0;
    #1;
    check("arst_warm_vld_a", vld_a, 0);
    check("arst_warm_rdy_a", rdy_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_rdy_a", rdy_a, 1);
    s = $urandom | 32'h1;
    sa = s; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    mc = s;
    check("w0_vld_c", vld_c, 1);
    check("w0_rnd_c", rnd_c, mc[5:0]);
    check("w0_vld_a", vld_a, 0);
    for (int j = 0; j < 6; j++) begin
      ena = 1'($urandom);
      @(negedge clk);
      if (ena) mc = adv(mc);
      ena = 1'b0;
      check("run_rnd_c", rnd_c, mc[5:0]);
    end
    do_reset();
    sb = 32'hAAAA_AAAA; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("gap_rdy_b", rdy_b, 1);
      check("gap_vld_b", vld_b, 0);
      @(negedge clk);
    end
    sb = 32'h5555_5555; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    mb0 = 32'hAAAA_AAAA; mb1 = 32'h5555_5555;
    for (int w = 0; w < 2; w++) begin
      check("warm_rdy_b", rdy_b, 0);
      check("warm_vld_b", vld_b, 0);
      mb0 = adv(mb0); mb1 = adv(mb1);
      enb = 1'($urandom);
      @(negedge clk);
    end
    enb = 1'b0;
    check("vld_rise_b", vld_b, 1);
    check("rnd_b", rnd_b, {mb1[7:0], mb0});
    for (int j = 0; j < 20; j++) consume_b(1'($urandom));
`ifdef RND_HEALTH_EN
    check("hlt_ok_b", fail_b, 0);
    force dut_b.g_l[0].u_l.q_q = 32'h0;
    @(negedge clk);
    release dut_b.g_l[0].u_l.q_q;
    check("hlt_fail_b", fail_b, 1);
    check("hlt_vld_b", vld_b, 0);
    @(negedge clk);
    check("hlt_sticky_b", fail_b, 1);
    sb = $urandom; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    check("hlt_clr_b", fail_b, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
